// File: rtl/sc_level_timer.sv
// rtl/sc_level_timer.sv - band-paced enemy-load pulse generator with level counter
//
// Purpose: divides the 50 MHz clock by a band-dependent period. Each expiry
// emits a one-cycle LOAD pulse and advances LEVEL. The run ends at LV_MAX.
// Optional feature macro: SC_LEVELTIMER_PAUSE_EN (adds SC_LEVELTIMER_PAUSE_InHigh).
//
// Ports:
//   SC_LEVELTIMER_CLOCK_50        in   system clock, rising edge
//   SC_LEVELTIMER_RESET_InHigh    in   synchronous reset, active high
//   SC_LEVELTIMER_START_InLow     in   start request, active low, level sampled
//   SC_LEVELTIMER_PAUSE_InHigh    in   freeze counting in RUN (macro only)
//   SC_LEVELTIMER_LOAD_OutHigh    out  one-cycle pulse per period expiry
//   SC_LEVELTIMER_LEVEL_Out       out  current level count
//   SC_LEVELTIMER_BAND_Out        out  0 idle, 1/2/3 active difficulty band
//   SC_LEVELTIMER_RUNNING_OutHigh out  high while in RUN
//   SC_LEVELTIMER_DONE_OutHigh    out  high while in DONE
module sc_level_timer #(
    parameter int TIMER_WIDTH = 25,
    parameter int LEVEL_WIDTH = 8,
    parameter int PERIOD_1    = 17500000,
    parameter int PERIOD_2    = 15000000,
    parameter int PERIOD_3    = 12500000,
    parameter int BAND1_END   = 10,
    parameter int BAND2_END   = 32,
    parameter int LV_MAX      = 59
) (
    input  logic                   SC_LEVELTIMER_CLOCK_50,
    input  logic                   SC_LEVELTIMER_RESET_InHigh,
    input  logic                   SC_LEVELTIMER_START_InLow,
`ifdef SC_LEVELTIMER_PAUSE_EN
    input  logic                   SC_LEVELTIMER_PAUSE_InHigh,
`endif
    output logic                   SC_LEVELTIMER_LOAD_OutHigh,
    output logic [LEVEL_WIDTH-1:0] SC_LEVELTIMER_LEVEL_Out,
    output logic [1:0]             SC_LEVELTIMER_BAND_Out,
    output logic                   SC_LEVELTIMER_RUNNING_OutHigh,
    output logic                   SC_LEVELTIMER_DONE_OutHigh
);

    // Period constants are truncated to the timer width.
    localparam logic [TIMER_WIDTH-1:0] RELOAD_1 = TIMER_WIDTH'(PERIOD_1 - 1);
    localparam logic [TIMER_WIDTH-1:0] RELOAD_2 = TIMER_WIDTH'(PERIOD_2 - 1);
    localparam logic [TIMER_WIDTH-1:0] RELOAD_3 = TIMER_WIDTH'(PERIOD_3 - 1);

    generate
        if (longint'(PERIOD_1) - 1 >= (longint'(1) << TIMER_WIDTH)) begin : g_bad_timer_width
            $error("sc_level_timer: PERIOD_1-1 does not fit in TIMER_WIDTH");
        end
        if (longint'(LV_MAX) >= (longint'(1) << LEVEL_WIDTH)) begin : g_bad_level_width
            $error("sc_level_timer: LV_MAX does not fit in LEVEL_WIDTH");
        end
        if (!(BAND1_END < BAND2_END && BAND2_END < LV_MAX)) begin : g_bad_bands
            $error("sc_level_timer: band limits must satisfy BAND1_END < BAND2_END < LV_MAX");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   state, state_n;
    logic [TIMER_WIDTH-1:0]   timer, timer_n;
    logic [LEVEL_WIDTH-1:0]   level, level_n;
    logic [1:0]               band, band_n;
    logic                     load, load_n;
    logic                     running, running_n;
    logic                     done, done_n;
    logic                     paused;
    logic [LEVEL_WIDTH-1:0]   level_inc;
    logic [1:0]               band_inc;

`ifdef SC_LEVELTIMER_PAUSE_EN
    assign paused = SC_LEVELTIMER_PAUSE_InHigh;
`else
    assign paused = 1'b0;
`endif

    function automatic logic [1:0] band_of(input logic [LEVEL_WIDTH-1:0] lv);
        if (int'(lv) <= BAND1_END)      return 2'd1;
        else if (int'(lv) <= BAND2_END) return 2'd2;
        else                            return 2'd3;
    endfunction

    function automatic logic [TIMER_WIDTH-1:0] reload_of(input logic [1:0] b);
        case (b)
            2'd1:    return RELOAD_1;
            2'd2:    return RELOAD_2;
            default: return RELOAD_3;
        endcase
    endfunction

    // The reload after an expiry is chosen from the band of the new level.
    assign level_inc = level + LEVEL_WIDTH'(1);
    assign band_inc  = band_of(level_inc);

    always_ff @(posedge SC_LEVELTIMER_CLOCK_50) begin
        if (SC_LEVELTIMER_RESET_InHigh) begin
            state   <= S_IDLE;
            timer   <= '0;
            level   <= '0;
            band    <= 2'd0;
            load    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            level   <= level_n;
            band    <= band_n;
            load    <= load_n;
            running <= running_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        level_n   = level;
        band_n    = band;
        load_n    = 1'b0;
        running_n = running;
        done_n    = done;
        case (state)
            S_IDLE: begin
                if (!SC_LEVELTIMER_START_InLow) begin
                    state_n   = S_RUN;
                    timer_n   = RELOAD_1;
                    level_n   = '0;
                    band_n    = 2'd1;
                    running_n = 1'b1;
                end
            end
            S_RUN: begin
                // A pause on the expiry cycle defers the pulse rather than dropping it.
                if (paused) begin
                    load_n = 1'b0;
                end else if (timer != '0) begin
                    timer_n = timer - TIMER_WIDTH'(1);
                end else begin
                    load_n  = 1'b1;
                    level_n = level_inc;
                    band_n  = band_inc;
                    if (int'(level_inc) == LV_MAX) begin
                        state_n   = S_DONE;
                        timer_n   = '0;
                        running_n = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        timer_n = reload_of(band_inc);
                    end
                end
            end
            S_DONE: begin
                load_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign SC_LEVELTIMER_LOAD_OutHigh    = load;
    assign SC_LEVELTIMER_LEVEL_Out       = level;
    assign SC_LEVELTIMER_BAND_Out        = band;
    assign SC_LEVELTIMER_RUNNING_OutHigh = running;
    assign SC_LEVELTIMER_DONE_OutHigh    = done;

endmodule

// File: tb/tb_sc_level_timer.sv
// tb/tb_sc_level_timer.sv - self-checking bench for sc_level_timer
module tb_sc_level_timer;

    localparam int P1 = 5;
    localparam int P2 = 4;
    localparam int P3 = 3;
    localparam int B1 = 2;
    localparam int B2 = 4;
    localparam int LVM = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_n = 1'b1;
    logic       pause = 1'b0;
    logic       load;
    logic [7:0] level;
    logic [1:0] band;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_level_timer #(
        .TIMER_WIDTH(25), .LEVEL_WIDTH(8),
        .PERIOD_1(P1), .PERIOD_2(P2), .PERIOD_3(P3),
        .BAND1_END(B1), .BAND2_END(B2), .LV_MAX(LVM)
    ) dut (
        .SC_LEVELTIMER_CLOCK_50(clk),
        .SC_LEVELTIMER_RESET_InHigh(rst),
        .SC_LEVELTIMER_START_InLow(start_n),
`ifdef SC_LEVELTIMER_PAUSE_EN
        .SC_LEVELTIMER_PAUSE_InHigh(pause),
`endif
        .SC_LEVELTIMER_LOAD_OutHigh(load),
        .SC_LEVELTIMER_LEVEL_Out(level),
        .SC_LEVELTIMER_BAND_Out(band),
        .SC_LEVELTIMER_RUNNING_OutHigh(running),
        .SC_LEVELTIMER_DONE_OutHigh(done)
    );

    // Reference model: absolute-time schedule of the next pulse.
    // mode: 0 idle, 1 running, 2 finished.
    int cyc = 0;
    int m_mode = 0;
    int m_level = 0;
    int m_load = 0;
    int m_next = 0;
    int t0 = 0;
    int pulses[$];

    function automatic int band_of(input int lv);
        return (lv <= B1) ? 1 : (lv <= B2) ? 2 : 3;
    endfunction

    function automatic int period_of(input int b);
        return (b == 1) ? P1 : (b == 2) ? P2 : P3;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic paused_now;
`ifdef SC_LEVELTIMER_PAUSE_EN
        paused_now = pause;
`else
        paused_now = 1'b0;
`endif
        m_load = 0;
        if (rst) begin
            m_mode = 0;
            m_level = 0;
        end else if (m_mode == 0) begin
            if (!start_n) begin
                m_mode = 1;
                m_level = 0;
                m_next = cyc + P1;
            end
        end else if (m_mode == 1) begin
            if (paused_now) begin
                m_next++;
            end else if (cyc == m_next) begin
                m_load = 1;
                m_level++;
                if (m_level == LVM) m_mode = 2;
                else m_next = cyc + period_of(band_of(m_level));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("load", int'(load), m_load);
        check("level", int'(level), m_level);
        check("band", int'(band), (m_mode == 0) ? 0 : band_of(m_level));
        check("running", int'(running), (m_mode == 1) ? 1 : 0);
        check("done", int'(done), (m_mode == 2) ? 1 : 0);
        if (load === 1'b1) pulses.push_back(cyc - t0);
    endtask

    task automatic start_run();
        start_n = 1'b0;
        step();
        t0 = cyc;
        start_n = 1'b1;
        pulses.delete();
    endtask

    initial begin
        int exp_p[6];
        exp_p = '{5, 10, 15, 19, 23, 26};

        // Reset with START low: reset wins.
        rst = 1'b1;
        start_n = 1'b0;
        step();
        step();
        check("rst_idle_level", int'(level), 0);
        rst = 1'b0;
        start_n = 1'b1;
        pulses.delete();
        for (int i = 0; i < 10; i++) step();
        check("idle_no_load", pulses.size(), 0);

        // Full run and pulse schedule.
        start_run();
        for (int i = 0; i < 35; i++) step();
        check("full_pulse_count", pulses.size(), 6);
        for (int i = 0; i < 6 && i < pulses.size(); i++)
            check("full_pulse_cycle", pulses[i], exp_p[i]);
        if (pulses.size() >= 4)
            check("band_edge_interval", pulses[3] - pulses[2], 4);
        check("full_done", int'(done), 1);
        check("full_level", int'(level), LVM);

        // DONE hold while START toggles.
        pulses.delete();
        for (int i = 0; i < 20; i++) begin
            start_n = i[0];
            step();
        end
        check("done_no_load", pulses.size(), 0);
        check("done_hold", int'(done), 1);

        // Reset mid-run at cycle 12.
        rst = 1'b1; start_n = 1'b1; step(); rst = 1'b0;
        start_run();
        while (cyc - t0 < 12) step();
        check("mid_level", int'(level), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_running", int'(running), 0);
        start_run();
        for (int i = 0; i < 6; i++) step();
        check("restart_first_load", (pulses.size() > 0) ? pulses[0] : -1, 5);

`ifdef SC_LEVELTIMER_PAUSE_EN
        // Pause 7 cycles starting at cycle 3 defers first load to 12.
        rst = 1'b1; step(); rst = 1'b0;
        start_run();
        while (cyc - t0 < 13) begin
            pause = ((cyc - t0) >= 2 && (cyc - t0) < 9);
            step();
        end
        pause = 1'b0;
        check("pause_first_load", (pulses.size() > 0) ? pulses[0] : -1, 12);
`endif

        // Randomized traffic against the model.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            start_n = ($urandom_range(0, 7) != 0);
            pause = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
